varies_frame_reg: RTL

Register bank feeding the 16 two-digit values shown by the on-screen ASCII overlay stage. It parses a simple byte-packet protocol from the UART receiver into a shadow bank, clamps each value to 0–99, and commits the shadow to the output bus only at the last pixel of a video frame, so a displayed number never changes mid-frame. It sits directly upstream of the overlay and counts the same pixel-valid stream the overlay consumes.

---
 rtl/varies_frame_reg_pkg.sv | 41 ++++
 rtl/varies_rx_parser.sv | 101 ++++++++++
 rtl/varies_frame_reg.sv | 77 +++++++
 3 files changed

// File: rtl/varies_frame_reg_pkg.sv
// Shared constants, parser state type and value clamp for the overlay register bank.
// Optional build macro: VARIES_CHECKSUM_EN (4-byte packets with a trailing checksum byte).
`ifndef POSITION_WIDTH
`define POSITION_WIDTH 12
`endif
`ifndef OV5640_X
`define OV5640_X 640
`endif
`ifndef OV5640_Y
`define OV5640_Y 480
`endif
`ifndef VARIES_HDR
`define VARIES_HDR 8'hA5
`endif
`ifndef VARIES_MAX
`define VARIES_MAX 8'd99
`endif
`ifndef VARIES_NUM
`define VARIES_NUM 16
`endif

package varies_frame_reg_pkg;
    localparam logic [7:0]  HDR  = `VARIES_HDR;
    localparam logic [7:0]  VMAX = `VARIES_MAX;
    localparam int unsigned NUM  = `VARIES_NUM;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
`ifdef VARIES_CHECKSUM_EN
        ST_DATA,
        ST_SUM
`else
        ST_DATA
`endif
    } rx_state_t;

    function automatic logic [7:0] clamp_value(input logic [7:0] v);
        return (v > VMAX) ? VMAX : v;
    endfunction
endpackage

// File: rtl/varies_rx_parser.sv
// Byte-packet parser: header/index/value(/checksum) FSM with inter-byte timeout and value clamp.
// Optional build macro: VARIES_CHECKSUM_EN adds the SUM state and checksum check.
module varies_rx_parser
    import varies_frame_reg_pkg::*;
#(
    parameter int unsigned P_TIMEOUT = 50000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       wr_en,
    output logic [3:0] wr_idx,
    output logic [7:0] wr_val,
    output logic       err
);
    localparam int unsigned   TW       = $clog2(P_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(P_TIMEOUT - 1);

    rx_state_t     state, state_n;
    logic [TW-1:0] tmo, tmo_n;
    logic [3:0]    idx, idx_n;
    logic          err_n;
`ifdef VARIES_CHECKSUM_EN
    logic [7:0]    val, val_n;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_IDLE;
            tmo   <= '0;
            idx   <= '0;
            err   <= 1'b0;
`ifdef VARIES_CHECKSUM_EN
            val   <= '0;
`endif
        end else begin
            state <= state_n;
            tmo   <= tmo_n;
            idx   <= idx_n;
            err   <= err_n;
`ifdef VARIES_CHECKSUM_EN
            val   <= val_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        tmo_n   = tmo;
        idx_n   = idx;
        err_n   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_val  = clamp_value(rx_data);
`ifdef VARIES_CHECKSUM_EN
        val_n   = val;
`endif
        if (rx_valid) begin
            tmo_n = '0;
            case (state)
                ST_IDLE: if (rx_data == HDR) state_n = ST_ADDR;
                ST_ADDR: begin
                    if (rx_data < 8'(NUM)) begin
                        idx_n   = rx_data[3:0];
                        state_n = ST_DATA;
                    end else begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                ST_DATA: begin
`ifdef VARIES_CHECKSUM_EN
                    val_n   = rx_data;
                    state_n = ST_SUM;
`else
                    wr_en   = 1'b1;
                    state_n = ST_IDLE;
`endif
                end
`ifdef VARIES_CHECKSUM_EN
                // checksum covers the raw value; only the stored copy is clamped
                ST_SUM: begin
                    wr_val  = clamp_value(val);
                    if (rx_data == 8'({4'd0, idx} + val)) wr_en = 1'b1;
                    else                                  err_n = 1'b1;
                    state_n = ST_IDLE;
                end
`endif
                default: state_n = ST_IDLE;
            endcase
        end else if (state != ST_IDLE) begin
            if (tmo == TMO_LAST) begin
                state_n = ST_IDLE;
                tmo_n   = '0;
            end else begin
                tmo_n = tmo + TW'(1);
            end
        end
    end
endmodule

// File: rtl/varies_frame_reg.sv
// Overlay value bank: shadow registers written by the packet parser, committed at the last frame pixel.
// Optional build macro: VARIES_CHECKSUM_EN (forwarded to the parser).
module varies_frame_reg
    import varies_frame_reg_pkg::*;
#(
    parameter int unsigned P_W       = `POSITION_WIDTH,
    parameter int unsigned P_TIMEOUT = 50000,
    parameter int unsigned P_X       = `OV5640_X,
    parameter int unsigned P_Y       = `OV5640_Y
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             i_rx_valid,
    input  logic [7:0]       i_rx_data,
    input  logic             i_valid,
    output logic [NUM*8-1:0] o_varies,
    output logic             o_upd,
    output logic             o_err,
    output logic             o_pending
);
    localparam logic [P_W-1:0] X_LAST = P_W'(P_X - 1);
    localparam logic [P_W-1:0] Y_LAST = P_W'(P_Y - 1);

    logic             wr_en;
    logic [3:0]       wr_idx;
    logic [7:0]       wr_val;
    logic [NUM*8-1:0] shadow;
    logic [P_W-1:0]   cnt_x, cnt_y;
    logic             last_pix, commit;

    varies_rx_parser #(.P_TIMEOUT(P_TIMEOUT)) u_parser (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .rx_valid (i_rx_valid),
        .rx_data  (i_rx_data),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_val   (wr_val),
        .err      (o_err)
    );

    assign last_pix = i_valid && (cnt_x == X_LAST) && (cnt_y == Y_LAST);
    assign commit   = last_pix && o_pending;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_x <= '0;
            cnt_y <= '0;
        end else if (i_valid) begin
            if (cnt_x == X_LAST) begin
                cnt_x <= '0;
                cnt_y <= (cnt_y == Y_LAST) ? '0 : cnt_y + P_W'(1);
            end else begin
                cnt_x <= cnt_x + P_W'(1);
            end
        end
    end

    // a write on the commit edge lands after the copy, so it stays pending for next frame
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            shadow    <= '0;
            o_varies  <= '0;
            o_upd     <= 1'b0;
            o_pending <= 1'b0;
        end else begin
            o_upd <= commit;
            if (commit) o_varies <= shadow;
            if (wr_en) begin
                shadow[{wr_idx, 3'b000} +: 8] <= wr_val;
                o_pending <= 1'b1;
            end else if (commit) begin
                o_pending <= 1'b0;
            end
        end
    end
endmodule
